alu_request_arbiter: RTL and testbench

//  Shares one alu_32 between NUM_REQ requesters (decode, branch compare, address calc).

---
 rtl/alu_arb_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 37 +++
 rtl/alu_request_arbiter.sv | 173 +++++++++++++++++
 tb/tb_alu_request_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU request arbiter.
//   arb_state_e : arbiter FSM states
//   Ctrl*       : alu_32 control codes
//   Flag*       : bit positions inside resp_flags
//   idx_width() : width of a requester index (minimum 1 bit)
package alu_arb_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StStart = 3'd2,
    StWait  = 3'd3,
    StResp  = 3'd4
  } arb_state_e;

  localparam logic [3:0] CtrlAnd  = 4'h0;
  localparam logic [3:0] CtrlOr   = 4'h1;
  localparam logic [3:0] CtrlAdd  = 4'h2;
  localparam logic [3:0] CtrlAddu = 4'h3;
  localparam logic [3:0] CtrlSub  = 4'h6;
  localparam logic [3:0] CtrlSlt  = 4'h7;
  localparam logic [3:0] CtrlNor  = 4'hC;

  localparam int unsigned FlagZero     = 0;
  localparam int unsigned FlagCout     = 1;
  localparam int unsigned FlagOverflow = 2;
  localparam int unsigned FlagInvalid  = 3;
  localparam int unsigned FlagTimeout  = 4;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req       : request vector
//   ptr       : highest-priority index this round
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : encoded index of the grant
//   any       : at least one request present
module rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdxW = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IdxW-1:0]    grant_idx,
  output logic               any
);

  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    // Scan from ptr upwards with wrap; first hit wins.
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(ptr) + off) % NUM_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_request_arbiter.sv
// Shares one alu_32 among NUM_REQ requesters, one operation in flight.
// Sequence per op: IDLE (grant) -> ISSUE (operand setup) -> START (alu_start pulse)
// -> WAIT (until alu_finished) -> RESP (single-cycle tagged response).
// Optional feature macro: ALU_ARB_TIMEOUT_EN enables a WAIT-state watchdog that
// aborts after TIMEOUT_CYC cycles with resp_flags timeout bit set and result 0.
// Ports:
//   clk, reset (async active-high)
//   req_valid/req_a/req_b/req_control : packed per-requester request slices
//   req_ready                         : one-hot accept pulse
//   resp_valid/resp_id/resp_result/resp_flags : response broadcast,
//     flags = {timeout, invalid_ctrl, overflow, cout, zero}
//   alu_start/alu_input_a/alu_input_b/alu_control : toward alu_32
//   alu_finished/alu_result/alu_zero/alu_cout/alu_err_* : from alu_32
module alu_request_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned TIMEOUT_CYC = 8,
  localparam int unsigned IdxW = idx_width(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_a,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_b,
  input  logic [NUM_REQ*4-1:0]           req_control,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           resp_valid,
  output logic [IdxW-1:0]                resp_id,
  output logic [WORD_SIZE-1:0]           resp_result,
  output logic [4:0]                     resp_flags,
  output logic                           alu_start,
  output logic [WORD_SIZE-1:0]           alu_input_a,
  output logic [WORD_SIZE-1:0]           alu_input_b,
  output logic [3:0]                     alu_control,
  input  logic                           alu_finished,
  input  logic                           alu_zero,
  input  logic                           alu_cout,
  input  logic                           alu_err_overflow,
  input  logic                           alu_err_invalid_control,
  input  logic [WORD_SIZE-1:0]           alu_result
);

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 15) begin : g_bad_param
    $error("alu_request_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYC 1..15");
  end

  arb_state_e           state_q;
  logic [IdxW-1:0]      ptr_q;
  logic [IdxW-1:0]      id_q;
  logic [WORD_SIZE-1:0] a_q, b_q;
  logic [3:0]           ctrl_q;

  logic [NUM_REQ-1:0]   grant;
  logic [IdxW-1:0]      grant_idx;
  logic                 grant_any;
  logic [WORD_SIZE-1:0] sel_a, sel_b;
  logic [3:0]           sel_ctrl;
  logic [IdxW-1:0]      ptr_next;
  logic                 wd_expire;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req      (req_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_idx(grant_idx),
    .any      (grant_any)
  );

  // Accept is only meaningful while idle; requests elsewhere are ignored.
  assign req_ready   = (state_q == StIdle) ? grant : '0;
  assign alu_input_a = a_q;
  assign alu_input_b = b_q;
  assign alu_control = ctrl_q;

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_ctrl = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a    = req_a[i*WORD_SIZE +: WORD_SIZE];
        sel_b    = req_b[i*WORD_SIZE +: WORD_SIZE];
        sel_ctrl = req_control[i*4 +: 4];
      end
    end
    ptr_next = (grant_idx == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

`ifdef ALU_ARB_TIMEOUT_EN
  logic [3:0] wd_q;

  // Counts consecutive WAIT cycles without alu_finished.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q <= '0;
    end else if (state_q == StWait && !alu_finished) begin
      wd_q <= wd_q + 4'd1;
    end else begin
      wd_q <= '0;
    end
  end

  assign wd_expire = (state_q == StWait) && (wd_q == 4'(TIMEOUT_CYC - 1));
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      alu_start   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
      resp_flags  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_any) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            ctrl_q  <= sel_ctrl;
            id_q    <= grant_idx;
            ptr_q   <= ptr_next;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          alu_start <= 1'b1;
          state_q   <= StStart;
        end
        StStart: begin
          alu_start <= 1'b0;
          state_q   <= StWait;
        end
        StWait: begin
          if (alu_finished) begin
            resp_valid  <= 1'b1;
            resp_id     <= id_q;
            resp_result <= alu_result;
            resp_flags  <= {1'b0, alu_err_invalid_control, alu_err_overflow, alu_cout, alu_zero};
            state_q     <= StResp;
          end else if (wd_expire) begin
            resp_valid  <= 1'b1;
            resp_id     <= id_q;
            resp_result <= '0;
            resp_flags  <= 5'(1 << FlagTimeout);
            state_q     <= StResp;
          end
        end
        StResp: begin
          resp_valid <= 1'b0;
          state_q    <= StIdle;
        end
        default: begin
          alu_start  <= 1'b0;
          resp_valid <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Directed bench for alu_request_arbiter with a behavioural alu_32 stand-in and
// a response scoreboard (expectation pushed at grant, popped at resp_valid).
module tb_alu_request_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned W    = 32;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        c;
    logic        ov;
    logic        inv;
  } alu_out_t;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic [4:0]  flags;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [31:0]       op_a [NREQ];
  logic [31:0]       op_b [NREQ];
  logic [3:0]        op_c [NREQ];
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ*4-1:0] req_control;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic [0:0]        resp_id;
  logic [W-1:0]      resp_result;
  logic [4:0]        resp_flags;
  logic              alu_start;
  logic [W-1:0]      alu_input_a, alu_input_b;
  logic [3:0]        alu_control;
  logic              alu_finished;
  logic [W-1:0]      alu_result;
  logic              alu_hold;
  alu_out_t          alu_o;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];

  assign req_a       = {op_a[1], op_a[0]};
  assign req_b       = {op_b[1], op_b[0]};
  assign req_control = {op_c[1], op_c[0]};

  always #5 clk = ~clk;

  function automatic alu_out_t alu_ref(input logic [31:0] a, input logic [31:0] b,
                                       input logic [3:0] ctrl);
    alu_out_t o;
    logic [32:0] s;
    o = '0;
    s = '0;
    case (ctrl)
      4'h0: o.r = a & b;
      4'h1: o.r = a | b;
      4'h2: begin
        s = {1'b0, a} + {1'b0, b};
        o.r = s[31:0];
        o.c = s[32];
        o.ov = (a[31] == b[31]) && (s[31] != a[31]);
      end
      4'h3: begin
        s = {1'b0, a} + {1'b0, b};
        o.r = s[31:0];
        o.c = s[32];
      end
      4'h6: begin
        s = {1'b0, a} - {1'b0, b};
        o.r = s[31:0];
        o.c = s[32];
        o.ov = (a[31] != b[31]) && (s[31] != a[31]);
      end
      4'h7: o.r = {31'b0, ($signed(a) < $signed(b))};
      4'hC: o.r = ~(a | b);
      default: o.inv = 1'b1;
    endcase
    o.z = (o.r == 32'b0);
    return o;
  endfunction

  // alu_32 stand-in: finishes the cycle after the start pulse unless held off.
  assign alu_o      = alu_ref(alu_input_a, alu_input_b, alu_control);
  assign alu_result = alu_o.r;
  always @(posedge clk) alu_finished <= alu_start && !alu_hold;

  alu_request_arbiter #(
    .NUM_REQ    (NREQ),
    .WORD_SIZE  (W),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .req_valid              (req_valid),
    .req_a                  (req_a),
    .req_b                  (req_b),
    .req_control            (req_control),
    .req_ready              (req_ready),
    .resp_valid             (resp_valid),
    .resp_id                (resp_id),
    .resp_result            (resp_result),
    .resp_flags             (resp_flags),
    .alu_start              (alu_start),
    .alu_input_a            (alu_input_a),
    .alu_input_b            (alu_input_b),
    .alu_control            (alu_control),
    .alu_finished           (alu_finished),
    .alu_zero               (alu_o.z),
    .alu_cout               (alu_o.c),
    .alu_err_overflow       (alu_o.ov),
    .alu_err_invalid_control(alu_o.inv),
    .alu_result             (alu_result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c);
    op_a[i] = a;
    op_b[i] = b;
    op_c[i] = c;
  endtask

  // Called from the low clock phase; waits for the accept, checks the granted
  // index, records the expected response and returns just after the accepting edge.
  task automatic step_grant(input int exp_idx, input bit tmo);
    int n;
    logic [NREQ-1:0] e;
    alu_out_t o;
    exp_t x;
    n = 0;
    #1;
    while (req_ready == '0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    e = '0;
    e[exp_idx] = 1'b1;
    check("grant", 64'(req_ready), 64'(e));
    o = alu_ref(op_a[exp_idx], op_b[exp_idx], op_c[exp_idx]);
    x.id = exp_idx;
    if (tmo) begin
      x.res = '0;
      x.flags = 5'b10000;
    end else begin
      x.res = o.r;
      x.flags = {1'b0, o.inv, o.ov, o.c, o.z};
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Follows one op from just after the accepting edge to its response; ends on
  // the low phase of the cycle after resp_valid.
  task automatic get_resp(input int exp_lat, output logic [31:0] r, output logic [4:0] f);
    int k;
    int start_k;
    int start_cnt;
    exp_t x;
    k = 0;
    start_k = -1;
    start_cnt = 0;
    r = 'x;
    f = 'x;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (alu_start) begin
        start_cnt++;
        if (start_k < 0) start_k = k;
      end
      if (resp_valid) break;
    end
    check("resp_latency", 64'(k), 64'(exp_lat));
    check("start_cycle", 64'(start_k), 64'd2);
    check("start_width", 64'(start_cnt), 64'd1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 64'd0, 64'd1);
    end else if (resp_valid) begin
      x = sb.pop_front();
      r = resp_result;
      f = resp_flags;
      check("resp_id", 64'(resp_id), 64'(x.id));
      check("resp_result", 64'(resp_result), 64'(x.res));
      check("resp_flags", 64'(resp_flags), 64'(x.flags));
    end
    @(negedge clk);
    check("resp_pulse", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [4:0]  f;
    reset = 1'b1;
    req_valid = '0;
    alu_hold = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h0, 32'h0, 4'h0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_state", {resp_valid, 1'(resp_id), resp_result, resp_flags, alu_start, req_ready},
          64'd0);
    check("rst_alu_ops", {alu_input_a, alu_input_b}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: single ADD from requester 0
    set_op(0, 32'd5, 32'd7, 4'h2);
    req_valid = 2'b01;
    step_grant(0, 1'b0);
    req_valid = '0;
    get_resp(4, r, f);
    check("t1_result", 64'(r), 64'd12);
    check("t1_zero", 64'(f[0]), 64'd0);
    repeat (2) @(negedge clk);
    check("resp_hold", 64'(resp_result), 64'd12);

    // 3: SUB equal operands, then signed overflow on ADD (requester 1)
    set_op(1, 32'd3, 32'd3, 4'h6);
    req_valid = 2'b10;
    step_grant(1, 1'b0);
    req_valid = '0;
    get_resp(4, r, f);
    check("t3_sub_result", 64'(r), 64'd0);
    check("t3_sub_zero", 64'(f[0]), 64'd1);
    set_op(1, 32'h7FFF_FFFF, 32'd1, 4'h2);
    req_valid = 2'b10;
    step_grant(1, 1'b0);
    req_valid = '0;
    get_resp(4, r, f);
    check("t3_ovf", 64'(f[2]), 64'd1);
    check("t3_ovf_result", 64'(r), 64'h8000_0000);

    // 2: both requesters held valid, back-to-back strict rotation
    set_op(0, 32'h0000_00F0, 32'h0000_000F, 4'h1);
    set_op(1, 32'h0, 32'h0, 4'hC);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step_grant(i % 2, 1'b0);
      get_resp(4, r, f);
    end
    req_valid = '0;
    @(negedge clk);

    // 4: invalid control code
    set_op(0, 32'h1234, 32'h5678, 4'h5);
    req_valid = 2'b01;
    step_grant(0, 1'b0);
    req_valid = '0;
    get_resp(4, r, f);
    check("t4_invalid", 64'(f[3]), 64'd1);

    // 5: reset during WAIT drops the op; pointer restarts at 0
    alu_hold = 1'b1;
    set_op(1, 32'd9, 32'd9, 4'h2);
    req_valid = 2'b10;
    step_grant(1, 1'b0);
    req_valid = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_outputs", {resp_valid, 1'(resp_id), resp_result, resp_flags, alu_start, req_ready},
          64'd0);
    check("t5_alu_ops", {alu_input_a, alu_input_b}, 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    check("t5_no_resp", 64'(resp_valid), 64'd0);
    alu_hold = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    set_op(0, 32'd1, 32'd2, 4'h2);
    req_valid = 2'b11;
    step_grant(0, 1'b0);
    req_valid = '0;
    get_resp(4, r, f);

`ifdef ALU_ARB_TIMEOUT_EN
    // 6: watchdog abort after 8 WAIT cycles
    alu_hold = 1'b1;
    set_op(1, 32'd4, 32'd4, 4'h2);
    req_valid = 2'b10;
    step_grant(1, 1'b1);
    req_valid = '0;
    get_resp(11, r, f);
    check("t6_timeout", 64'(f[4]), 64'd1);
    alu_hold = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
